// File: rtl/crc8_frame_ctrl.sv
// rtl/crc8_frame_ctrl.sv - CRC-8 (poly 0x07) inline frame sequencer: GEN appends, CHECK verifies the trailing CRC byte

module calc_crc (
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);
  logic [7:0] c;

  always_comb begin
    c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    crc_o = c;
  end
endmodule

module crc8_frame_ctrl #(
  parameter logic [7:0] INIT    = 8'h00,
  parameter logic [7:0] XOR_OUT = 8'h00,
  parameter int         LEN_W   = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             MODE_I,
  input  logic [7:0]       S_DATA_I,
  input  logic             S_VALID_I,
  input  logic             S_LAST_I,
  output logic             S_READY_O,
  output logic [7:0]       M_DATA_O,
  output logic             M_VALID_O,
  output logic             M_LAST_O,
  input  logic             M_READY_I,
  output logic [7:0]       CRC_O,
  output logic             CRC_ERR_O,
  output logic [LEN_W-1:0] LEN_O,
  output logic             DONE_O
);
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_APPEND} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [7:0]         crc_q, crc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic [7:0]         crc_out_q, crc_out_d;
  logic               crc_err_q, crc_err_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic               accept;
  logic               out_fire;
  logic               cur_mode;
  logic [7:0]         crc_upd;
  logic [LEN_W-1:0]   cnt_nxt;

  calc_crc u_calc_crc (
    .crc_i  (crc_q),
    .data_i (S_DATA_I),
    .crc_o  (crc_upd)
  );

  assign S_READY_O = (state_q != ST_APPEND) && (!m_valid_q || M_READY_I);
  assign accept    = S_VALID_I && S_READY_O;
  assign out_fire  = m_valid_q && M_READY_I;
  // Mode is frozen by the first accepted byte; later MODE_I changes are ignored.
  assign cur_mode  = (state_q == ST_IDLE) ? MODE_I : mode_q;
  assign cnt_nxt   = (state_q == ST_IDLE) ? LEN_W'(1) :
                     ((&cnt_q) ? cnt_q : cnt_q + LEN_W'(1));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    crc_out_d = crc_out_q;
    crc_err_d = crc_err_q;
    len_d     = len_q;

    if (out_fire) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if (state_q == ST_APPEND) begin
      // m_last_q marks the CRC byte already loaded; otherwise the last payload byte is still draining.
      if (m_valid_q && m_last_q) begin
        if (M_READY_I) state_d = ST_IDLE;
      end else if (!m_valid_q || M_READY_I) begin
        m_data_d  = crc_out_q;
        m_valid_d = 1'b1;
        m_last_d  = 1'b1;
      end
    end else if (accept) begin
      mode_d    = cur_mode;
      cnt_d     = cnt_nxt;
      m_data_d  = S_DATA_I;
      m_valid_d = 1'b1;
      m_last_d  = S_LAST_I && cur_mode;
      if (S_LAST_I) begin
        crc_d = INIT;
        len_d = cnt_nxt;
        if (cur_mode) begin
          crc_out_d = crc_q ^ XOR_OUT;
          crc_err_d = (S_DATA_I != (crc_q ^ XOR_OUT));
          state_d   = ST_IDLE;
        end else begin
          crc_out_d = crc_upd ^ XOR_OUT;
          crc_err_d = 1'b0;
          state_d   = ST_APPEND;
        end
      end else begin
        crc_d   = crc_upd;
        state_d = ST_DATA;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      crc_q     <= INIT;
      cnt_q     <= '0;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      crc_out_q <= 8'h00;
      crc_err_q <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      crc_out_q <= crc_out_d;
      crc_err_q <= crc_err_d;
      len_q     <= len_d;
    end
  end

  assign M_DATA_O  = m_data_q;
  assign M_VALID_O = m_valid_q;
  assign M_LAST_O  = m_last_q;
  assign CRC_O     = crc_out_q;
  assign CRC_ERR_O = crc_err_q;
  assign LEN_O     = len_q;
  assign DONE_O    = m_valid_q && M_READY_I && m_last_q && !RST_I;
endmodule
